pipeline_reg_idex_skid: RTL and testbench

PIPELINE_REG_IDEX_SKID -- requirements
Module: pipeline_reg_idex_skid

---
 rtl/pipeline_reg_idex_skid_pkg.sv | 17 +
 rtl/pipeline_reg_idex_skid_skid_ctrl.sv | 49 ++++
 rtl/pipeline_reg_idex_skid.sv | 103 ++++++++++
 tb/tb_pipeline_reg_idex_skid.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_reg_idex_skid_pkg.sv
// Shared widths and occupancy encoding for the ID/EX skid pipeline register.
// The top exposes stall_cnt only when built with IDEX_STALL_CNT_EN.
package pipeline_reg_idex_skid_pkg;

  localparam int unsigned COMMON_WIDTH   = 32;
  localparam int unsigned REG_NUM        = 5;
  localparam int unsigned ALU_TYPE_WIDTH = 4;

  localparam logic [31:0] STALL_CNT_MAX = '1;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_MAIN  = 2'd1,
    OCC_BOTH  = 2'd2
  } occ_e;

endpackage

// File: rtl/pipeline_reg_idex_skid_skid_ctrl.sv
// Occupancy control for the main/skid entry pair: valid bits, load enables and in_ready.
// in_ready is decoded from state only, so out_ready never reaches it combinationally.
module skid_ctrl
  import pipeline_reg_idex_skid_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic main_load,
  output logic main_from_skid,
  output logic skid_load
);

  occ_e r_state;
  logic w_accept;
  logic w_advance;

  assign in_ready       = (r_state != OCC_BOTH);
  assign out_valid      = (r_state != OCC_EMPTY);
  assign w_accept       = in_valid & in_ready & ~flush;
  assign w_advance      = ~out_valid | out_ready;
  assign main_from_skid = (r_state == OCC_BOTH);
  assign main_load      = ~flush & w_advance & (main_from_skid | w_accept);
  assign skid_load      = ~flush & ~w_advance & w_accept;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= OCC_EMPTY;
    end else if (flush) begin
      r_state <= OCC_EMPTY;
    end else begin
      case (r_state)
        OCC_EMPTY: if (in_valid) r_state <= OCC_MAIN;
        OCC_MAIN: begin
          if (out_ready && !in_valid)      r_state <= OCC_EMPTY;
          else if (!out_ready && in_valid) r_state <= OCC_BOTH;
        end
        // A full skid blocks input, so a drain only ever drops one entry.
        OCC_BOTH:  if (out_ready) r_state <= OCC_MAIN;
        default:   r_state <= OCC_EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_reg_idex_skid.sv
// ID/EX pipeline register with a skid entry; src2/imm mux applied at capture.
// Define IDEX_STALL_CNT_EN to add the saturating stall_cnt back-pressure counter port.
module pipeline_reg_idex_skid
  import pipeline_reg_idex_skid_pkg::*;
#(
  parameter int unsigned DATA_W = COMMON_WIDTH,
  parameter int unsigned REG_W  = REG_NUM,
  parameter int unsigned ALU_W  = ALU_TYPE_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ALU_W-1:0]  alu_type_in,
  input  logic [REG_W-1:0]  rd_in,
  input  logic [DATA_W-1:0] src1_in,
  input  logic [DATA_W-1:0] src2_in,
  input  logic              imm_tag,
  input  logic [DATA_W-1:0] imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ALU_W-1:0]  alu_type,
  output logic [REG_W-1:0]  rd,
  output logic [DATA_W-1:0] src1,
  output logic [DATA_W-1:0] src2_imm
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  logic              w_main_load;
  logic              w_main_from_skid;
  logic              w_skid_load;
  logic [DATA_W-1:0] w_src2_imm_in;

  logic [ALU_W-1:0]  r_alu_type,  r_sk_alu_type;
  logic [REG_W-1:0]  r_rd,        r_sk_rd;
  logic [DATA_W-1:0] r_src1,      r_sk_src1;
  logic [DATA_W-1:0] r_src2_imm,  r_sk_src2_imm;

  skid_ctrl u_skid_ctrl (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .out_ready      (out_ready),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .main_load      (w_main_load),
    .main_from_skid (w_main_from_skid),
    .skid_load      (w_skid_load)
  );

  assign w_src2_imm_in = imm_tag ? imm : src2_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_alu_type    <= '0;
      r_rd          <= '0;
      r_src1        <= '0;
      r_src2_imm    <= '0;
      r_sk_alu_type <= '0;
      r_sk_rd       <= '0;
      r_sk_src1     <= '0;
      r_sk_src2_imm <= '0;
    end else begin
      if (w_main_load) begin
        r_alu_type <= w_main_from_skid ? r_sk_alu_type : alu_type_in;
        r_rd       <= w_main_from_skid ? r_sk_rd       : rd_in;
        r_src1     <= w_main_from_skid ? r_sk_src1     : src1_in;
        r_src2_imm <= w_main_from_skid ? r_sk_src2_imm : w_src2_imm_in;
      end
      if (w_skid_load) begin
        r_sk_alu_type <= alu_type_in;
        r_sk_rd       <= rd_in;
        r_sk_src1     <= src1_in;
        r_sk_src2_imm <= w_src2_imm_in;
      end
    end
  end

  assign alu_type = r_alu_type;
  assign rd       = r_rd;
  assign src1     = r_src1;
  assign src2_imm = r_src2_imm;

`ifdef IDEX_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != STALL_CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_pipeline_reg_idex_skid.sv
// Bench for pipeline_reg_idex_skid at DATA_W=64, REG_W=6: directed scenarios plus
// random traffic, checked against a queue model of the held beats.
module tb_pipeline_reg_idex_skid;

  localparam int unsigned DW = 64;
  localparam int unsigned RW = 6;
  localparam int unsigned AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] alu_type_in;
  logic [RW-1:0] rd_in;
  logic [DW-1:0] src1_in;
  logic [DW-1:0] src2_in;
  logic          imm_tag;
  logic [DW-1:0] imm;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] alu_type;
  logic [RW-1:0] rd;
  logic [DW-1:0] src1;
  logic [DW-1:0] src2_imm;
`ifdef IDEX_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  pipeline_reg_idex_skid #(.DATA_W(DW), .REG_W(RW), .ALU_W(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_type_in (alu_type_in),
    .rd_in       (rd_in),
    .src1_in     (src1_in),
    .src2_in     (src2_in),
    .imm_tag     (imm_tag),
    .imm         (imm),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_type    (alu_type),
    .rd          (rd),
    .src1        (src1),
    .src2_imm    (src2_imm)
`ifdef IDEX_STALL_CNT_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] alu;
    logic [RW-1:0] rdv;
    logic [DW-1:0] s1;
    logic [DW-1:0] s2i;
  } beat_t;

  beat_t       q[$];
  logic [31:0] m_stall;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    check("in_ready", 64'(in_ready), 64'(q.size() < 2));
    check("out_valid", 64'(out_valid), 64'(q.size() > 0));
    if (q.size() > 0) begin
      check("alu_type", 64'(alu_type), 64'(q[0].alu));
      check("rd", 64'(rd), 64'(q[0].rdv));
      check("src1", src1, q[0].s1);
      check("src2_imm", src2_imm, q[0].s2i);
    end
`ifdef IDEX_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
  endtask

  task automatic reset_checks();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_alu_type", 64'(alu_type), 64'd0);
    check("rst_rd", 64'(rd), 64'd0);
    check("rst_src1", src1, 64'd0);
    check("rst_src2_imm", src2_imm, 64'd0);
`ifdef IDEX_STALL_CNT_EN
    check("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
  endtask

  // One cycle: check state at negedge, drive inputs, advance the model to the next posedge.
  task automatic drive(input bit iv, input bit ordy, input bit fl, input bit tag,
                       input logic [AW-1:0] alu, input logic [RW-1:0] rdv,
                       input logic [DW-1:0] s1, input logic [DW-1:0] s2,
                       input logic [DW-1:0] im);
    bit    acc;
    beat_t b;
    @(negedge clk);
    check_outputs();
    in_valid    = iv;
    out_ready   = ordy;
    flush       = fl;
    imm_tag     = tag;
    alu_type_in = alu;
    rd_in       = rdv;
    src1_in     = s1;
    src2_in     = s2;
    imm         = im;
    acc   = iv && (q.size() < 2) && !fl;
    b.alu = alu;
    b.rdv = rdv;
    b.s1  = s1;
    b.s2i = tag ? im : s2;
    if (q.size() > 0 && !ordy && m_stall != 32'hFFFF_FFFF) m_stall++;
    if (fl) begin
      q.delete();
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (acc) q.push_back(b);
    end
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, ordy, 1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic beat(input bit ordy, input logic [DW-1:0] s1);
    drive(1'b1, ordy, 1'b0, s1[0], AW'(s1), RW'(s1), s1, ~s1, {s1[31:0], s1[63:32]});
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; imm_tag = 1'b0;
    alu_type_in = '0; rd_in = '0; src1_in = '0; src2_in = '0; imm = '0;
    m_stall = '0;
    #12;
    reset_checks();
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back stream, alternating immediate select, wide-value passthrough.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, i[0], AW'(i), (i == 0) ? RW'(63) : RW'(i),
            (i == 0) ? 64'hFFFF_FFFF_0000_0001 : 64'(i), 64'h11, 64'h22);
    end
    idle(1'b1);

    // Three stall cycles: A held in main, B in skid, C blocked then accepted.
    beat(1'b1, 64'hA);
    beat(1'b0, 64'hB);
    beat(1'b0, 64'hC);
    beat(1'b0, 64'hC);
    beat(1'b1, 64'hC);
    beat(1'b1, 64'hC);
    idle(1'b1);
    idle(1'b1);

    // Flush with both entries full and a beat presented.
    beat(1'b0, 64'h100);
    beat(1'b0, 64'h101);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 6'h2A, 64'hDEAD, 64'hBEEF, 64'h0);
    idle(1'b1);
    idle(1'b1);

    // Skid full while draining: input refused this cycle, accepted the next.
    beat(1'b0, 64'h200);
    beat(1'b0, 64'h201);
    beat(1'b1, 64'h202);
    beat(1'b1, 64'h202);
    idle(1'b1);
    idle(1'b1);

    // Reset mid-stall, then the first beat after release appears a cycle later.
    beat(1'b0, 64'h300);
    beat(1'b0, 64'h301);
    @(negedge clk);
    check_outputs();
    in_valid = 1'b0;
    #1 rst = 1'b0;
    #1 reset_checks();
    q.delete();
    m_stall = '0;
    @(negedge clk);
    rst = 1'b1;
    beat(1'b1, 64'h400);
    idle(1'b1);
    idle(1'b1);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 19) == 0), 1'($urandom),
            AW'($urandom), RW'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
    end
    for (int n = 0; n < 3; n++) idle(1'b1);
    @(negedge clk);
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
